// File: rtl/dma_bus_arbiter_pkg.sv
// Shared definitions for the DMA bus arbiter: FSM encoding, parameter defaults
// and the I/O address windows also decoded by the DMA block.
package dma_bus_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StCpuOwn  = 3'd0;
  localparam state_t StHoldReq = 3'd1;
  localparam state_t StDmaOwn  = 3'd2;
  localparam state_t StRelease = 3'd3;
  localparam state_t StCpuSlot = 3'd4;

  localparam int unsigned CountWDefault   = 6;
  localparam int unsigned MaxBurstDefault = 16;
  localparam int unsigned CpuSlotDefault  = 4;

  localparam logic [7:0] Io1AddrLo = 8'd192;
  localparam logic [7:0] Io1AddrHi = 8'd223;
  localparam logic [7:0] Io2AddrLo = 8'd224;
  localparam logic [7:0] Io2AddrHi = 8'd255;

  function automatic logic is_io_addr(input logic [7:0] addr);
    return (addr >= Io1AddrLo) && (addr <= Io2AddrHi);
  endfunction

endpackage

// File: rtl/dma_bus_arbiter_if.sv
// Request/grant and status signals between the DMA engine, processor and arbiter.
interface dma_bus_arbiter_if #(
  parameter int unsigned COUNT_W = 6
);
  logic               dma_req;
  logic [COUNT_W-1:0] dma_count;
  logic               dma_beat;
  logic               io_urgent;
  logic               cpu_ack;
  logic               cpu_hold;
  logic               grant;
  logic               busybus;
  logic [COUNT_W:0]   remaining;
  logic               xfer_done;
  logic               burst_end;
  logic               req_err;

  modport master (
    output dma_req, dma_count, dma_beat, io_urgent, cpu_ack,
    input  cpu_hold, grant, busybus, remaining, xfer_done, burst_end, req_err
  );

  modport slave (
    input  dma_req, dma_count, dma_beat, io_urgent, cpu_ack,
    output cpu_hold, grant, busybus, remaining, xfer_done, burst_end, req_err
  );
endinterface

// File: rtl/dma_bus_arbiter_beat_counter.sv
// Remaining-word down-counter and per-grant burst up-counter, with the
// look-ahead flags the arbiter FSM needs to decide on the beat edge itself.
module dma_beat_counter #(
  parameter int unsigned COUNT_W   = 6,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load,
  input  logic [COUNT_W-1:0] load_val,
  input  logic               clear,
  input  logic               beat,
  input  logic               burst_clr,
  output logic [COUNT_W:0]   remaining,
  output logic               rem_zero,
  output logic               rem_last,
  output logic               burst_last
);

  localparam int unsigned BurstW = $clog2(MAX_BURST + 1);
  localparam logic [COUNT_W:0]  RemOne    = 1;
  localparam logic [BurstW-1:0] BurstOne  = 1;
  localparam logic [BurstW-1:0] BurstLast = BurstW'(MAX_BURST - 1);

  logic [COUNT_W:0]  rem_q, rem_d;
  logic [BurstW-1:0] burst_q, burst_d;

  always_comb begin
    rem_d = rem_q;
    if (clear) begin
      rem_d = '0;
    end else if (load) begin
      rem_d = {1'b0, load_val};
    end else if (beat && (rem_q != '0)) begin
      rem_d = rem_q - RemOne;
    end

    burst_d = burst_q;
    if (burst_clr) begin
      burst_d = '0;
    end else if (beat) begin
      burst_d = burst_q + BurstOne;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rem_q   <= '0;
      burst_q <= '0;
    end else begin
      rem_q   <= rem_d;
      burst_q <= burst_d;
    end
  end

  assign remaining  = rem_q;
  assign rem_zero   = (rem_q == '0);
  // "last" flags mean the next accepted beat finishes the job / burst.
  assign rem_last   = (rem_q == RemOne);
  assign burst_last = (burst_q == BurstLast);

endmodule

// File: rtl/dma_bus_arbiter.sv
// Hands the shared bus between the processor and the DMA engine, capping
// DMA bursts and guaranteeing the processor a slot between grants.
module dma_bus_arbiter
  import dma_bus_pkg::*;
#(
  parameter int unsigned COUNT_W   = CountWDefault,
  parameter int unsigned MAX_BURST = MaxBurstDefault,
  parameter int unsigned CPU_SLOT  = CpuSlotDefault
) (
  input logic              clock,
  input logic              reset_n,
  dma_bus_arbiter_if.slave bus
);

  localparam int unsigned SlotW = $clog2(CPU_SLOT + 1);
  localparam logic [SlotW-1:0] SlotOne  = 1;
  localparam logic [SlotW-1:0] SlotLast = SlotW'(CPU_SLOT - 1);

  state_t           state_q, state_d;
  logic             hold_q, hold_d;
  logic             grant_q, grant_d;
  logic             xfer_done_q, xfer_done_d;
  logic             burst_end_q, burst_end_d;
  logic             req_err_q, req_err_d;
  logic [SlotW-1:0] slot_q, slot_d;

  logic             cnt_load, cnt_clear, beat_en, burst_clr;
  logic             rem_zero, rem_last, burst_last;
  logic [COUNT_W:0] remaining;

  dma_beat_counter #(
    .COUNT_W   (COUNT_W),
    .MAX_BURST (MAX_BURST)
  ) u_beat_counter (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (cnt_load),
    .load_val   (bus.dma_count),
    .clear      (cnt_clear),
    .beat       (beat_en),
    .burst_clr  (burst_clr),
    .remaining  (remaining),
    .rem_zero   (rem_zero),
    .rem_last   (rem_last),
    .burst_last (burst_last)
  );

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    grant_d     = grant_q;
    slot_d      = slot_q;
    xfer_done_d = 1'b0;
    burst_end_d = 1'b0;
    req_err_d   = 1'b0;
    cnt_load    = 1'b0;
    cnt_clear   = 1'b0;
    beat_en     = 1'b0;
    burst_clr   = 1'b0;

    case (state_q)
      StCpuOwn: begin
        if (rem_zero) begin
          if (bus.dma_req) begin
            if (bus.dma_count != '0) begin
              cnt_load = 1'b1;
              hold_d   = 1'b1;
              state_d  = StHoldReq;
            end else begin
              req_err_d = 1'b1;
            end
          end
        end else if (bus.dma_req) begin
          // Resume a split job; the latched count is kept.
          hold_d  = 1'b1;
          state_d = StHoldReq;
        end else begin
          cnt_clear = 1'b1;
        end
      end
      StHoldReq: begin
        if (bus.cpu_ack) begin
          grant_d   = 1'b1;
          burst_clr = 1'b1;
          state_d   = StDmaOwn;
        end else if (!bus.dma_req) begin
          hold_d    = 1'b0;
          cnt_clear = 1'b1;
          state_d   = StCpuOwn;
        end
      end
      StDmaOwn: begin
        if (bus.dma_beat) begin
          beat_en = 1'b1;
          if (rem_last) begin
            xfer_done_d = 1'b1;
            grant_d     = 1'b0;
            state_d     = StRelease;
          end else if (burst_last) begin
            burst_end_d = 1'b1;
            grant_d     = 1'b0;
            state_d     = StRelease;
          end
        end
      end
      StRelease: begin
        hold_d  = 1'b0;
        slot_d  = '0;
        state_d = StCpuSlot;
      end
      StCpuSlot: begin
        slot_d = slot_q + SlotOne;
        if ((slot_q == SlotLast) || (bus.io_urgent && !rem_zero)) begin
          state_d = StCpuOwn;
        end
      end
      default: begin
        hold_d  = 1'b0;
        grant_d = 1'b0;
        state_d = StCpuOwn;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StCpuOwn;
      hold_q      <= 1'b0;
      grant_q     <= 1'b0;
      slot_q      <= '0;
      xfer_done_q <= 1'b0;
      burst_end_q <= 1'b0;
      req_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      grant_q     <= grant_d;
      slot_q      <= slot_d;
      xfer_done_q <= xfer_done_d;
      burst_end_q <= burst_end_d;
      req_err_q   <= req_err_d;
    end
  end

  assign bus.cpu_hold  = hold_q;
  assign bus.grant     = grant_q;
  assign bus.busybus   = grant_q;
  assign bus.remaining = remaining;
  assign bus.xfer_done = xfer_done_q;
  assign bus.burst_end = burst_end_q;
  assign bus.req_err   = req_err_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench for dma_bus_arbiter: vector table for the basic flows plus
// hand-written split-burst, urgent-slot and asynchronous-reset sequences.
module tb_dma_bus_arbiter;

  logic clock;
  logic reset_n;
  int   tests;
  int   fails;
  int   beats;

  dma_bus_arbiter_if #(.COUNT_W(6)) bus_if ();

  dma_bus_arbiter #(
    .COUNT_W   (6),
    .MAX_BURST (16),
    .CPU_SLOT  (4)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       req;
    logic [5:0] cnt;
    logic       beat;
    logic       urg;
    logic       ack;
    logic       hold;
    logic       grant;
    logic [6:0] rem;
    logic       xd;
    logic       be;
    logic       re;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic req, input logic [5:0] cnt, input logic beat, input logic urg,
                     input logic ack, input logic hold, input logic grant, input logic [6:0] rem,
                     input logic xd, input logic be, input logic re);
    vec_t v;
    v.req = req; v.cnt = cnt; v.beat = beat; v.urg = urg; v.ack = ack;
    v.hold = hold; v.grant = grant; v.rem = rem; v.xd = xd; v.be = be; v.re = re;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic req, input logic [5:0] cnt, input logic beat,
                       input logic urg, input logic ack);
    bus_if.dma_req   = req;
    bus_if.dma_count = cnt;
    bus_if.dma_beat  = beat;
    bus_if.io_urgent = urg;
    bus_if.cpu_ack   = ack;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Runs a job of `cnt` words through its first 16-beat burst.
  task automatic start_burst(input logic [5:0] cnt, input logic urg);
    drive(1'b1, cnt, 1'b0, urg, 1'b1);
    tick();
    tick();
    chk("regrant_grant", 32'(bus_if.grant), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, cnt, 1'b1, urg, 1'b1);
      tick();
      beats++;
      if (i == 15) chk("burst_no_early_end", 32'(bus_if.burst_end), 32'd0);
    end
    chk("burst_end_pulse", 32'(bus_if.burst_end), 32'd1);
    chk("burst_end_rem", 32'(bus_if.remaining), 32'd4);
    chk("burst_end_grant", 32'(bus_if.grant), 32'd0);
    chk("burst_end_hold", 32'(bus_if.cpu_hold), 32'd1);
  endtask

  task automatic finish_job(input logic urg);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 6'd9, 1'b1, urg, 1'b1);
      tick();
      beats++;
    end
    chk("tail_xfer_done", 32'(bus_if.xfer_done), 32'd1);
    chk("tail_rem", 32'(bus_if.remaining), 32'd0);
    chk("tail_total_beats", 32'(beats), 32'd20);
    drive(1'b0, 6'd0, 1'b0, 1'b0, 1'b1);
    repeat (6) tick();
    chk("tail_idle_xfer_done", 32'(bus_if.xfer_done), 32'd0);
  endtask

  initial begin
    logic [12:0] got;
    logic [12:0] exp;
    tests = 0;
    fails = 0;
    drive(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #2;
    chk("reset_outputs",
        32'({bus_if.cpu_hold, bus_if.grant, bus_if.busybus, bus_if.remaining,
             bus_if.xfer_done, bus_if.burst_end, bus_if.req_err}), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // req cnt beat urg ack | hold grant rem xd be re
    add(1, 5, 0, 0, 1, 1, 0, 5, 0, 0, 0);   // HOLD_REQ
    add(1, 5, 0, 0, 1, 1, 1, 5, 0, 0, 0);   // granted 2 edges after req
    add(1, 5, 1, 0, 1, 1, 1, 4, 0, 0, 0);
    add(1, 5, 1, 0, 0, 1, 1, 3, 0, 0, 0);   // ack drop ignored while granted
    add(1, 5, 1, 0, 1, 1, 1, 2, 0, 0, 0);
    add(1, 5, 1, 0, 1, 1, 1, 1, 0, 0, 0);
    add(1, 5, 1, 0, 1, 1, 0, 0, 1, 0, 0);   // 5th beat: xfer_done, release
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);   // CPU slot
    add(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);   // back to CPU_OWN
    add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);   // zero count: req_err only
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 3, 0, 0, 0, 1, 0, 3, 0, 0, 0);   // HOLD_REQ, no ack
    add(1, 3, 1, 0, 0, 1, 0, 3, 0, 0, 0);   // beat outside DMA_OWN ignored
    add(0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // abandon: hold drops, rem cleared
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].req, vecs[i].cnt, vecs[i].beat, vecs[i].urg, vecs[i].ack);
      tick();
      got = {bus_if.cpu_hold, bus_if.grant, bus_if.busybus, bus_if.remaining,
             bus_if.xfer_done, bus_if.burst_end, bus_if.req_err};
      exp = {vecs[i].hold, vecs[i].grant, vecs[i].grant, vecs[i].rem,
             vecs[i].xd, vecs[i].be, vecs[i].re};
      chk($sformatf("vec%0d", i), 32'(got), 32'(exp));
    end

    // Split job, full CPU slot; count changed on the bus must not be re-sampled.
    beats = 0;
    start_burst(6'd20, 1'b0);
    drive(1'b1, 6'd9, 1'b0, 1'b0, 1'b1);
    tick();
    chk("split_slot_hold", 32'(bus_if.cpu_hold), 32'd0);
    repeat (4) tick();
    chk("split_slot_last_hold", 32'(bus_if.cpu_hold), 32'd0);
    tick();
    chk("split_rehold", 32'(bus_if.cpu_hold), 32'd1);
    chk("split_rem_kept", 32'(bus_if.remaining), 32'd4);
    tick();
    chk("split_regrant", 32'(bus_if.grant), 32'd1);
    finish_job(1'b0);

    // Split job with io_urgent: one-cycle processor slot.
    beats = 0;
    start_burst(6'd20, 1'b1);
    drive(1'b1, 6'd9, 1'b0, 1'b1, 1'b1);
    tick();
    chk("urg_slot_hold", 32'(bus_if.cpu_hold), 32'd0);
    tick();
    chk("urg_cpu_own_hold", 32'(bus_if.cpu_hold), 32'd0);
    tick();
    chk("urg_rehold", 32'(bus_if.cpu_hold), 32'd1);
    tick();
    chk("urg_regrant", 32'(bus_if.grant), 32'd1);
    finish_job(1'b1);

    // Asynchronous reset in the middle of a grant.
    drive(1'b1, 6'd10, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'd10, 1'b1, 1'b0, 1'b1);
      tick();
    end
    chk("rst_pre_rem", 32'(bus_if.remaining), 32'd7);
    chk("rst_pre_grant", 32'(bus_if.grant), 32'd1);
    reset_n = 1'b0;
    #2;
    chk("rst_async_grant", 32'(bus_if.grant), 32'd0);
    chk("rst_async_busybus", 32'(bus_if.busybus), 32'd0);
    chk("rst_async_hold", 32'(bus_if.cpu_hold), 32'd0);
    chk("rst_async_rem", 32'(bus_if.remaining), 32'd0);
    drive(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    #3;
    reset_n = 1'b1;
    tick();
    chk("rst_after_pulses",
        32'({bus_if.xfer_done, bus_if.burst_end, bus_if.req_err}), 32'd0);
    chk("rst_after_hold", 32'(bus_if.cpu_hold), 32'd0);
    chk("rst_after_rem", 32'(bus_if.remaining), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
